// File: rtl/cmd_dispatch_if.sv
// Handshake bundle between the ifq, the command dispatcher and the xfer_buffer.
// The master modport is the ifq/xfer_buffer side; the slave modport is the dispatcher.
interface cmd_dispatch_if;
  logic         sq_select;
  logic         sq_ready;
  logic [255:0] cmd_out;
  logic         xfer_buf_select;
  logic         mwrite_enable;
  logic [31:0]  tbm_address;
  logic         xfer_complete;
  logic         status_update_enable;
  logic [7:0]   cmdq_index;
  logic [1:0]   cmd_status;
  logic         busy;

  modport master (
    output sq_select, cmd_out, xfer_complete,
    input  sq_ready, xfer_buf_select, mwrite_enable, tbm_address,
           status_update_enable, cmdq_index, cmd_status, busy
  );

  modport slave (
    input  sq_select, cmd_out, xfer_complete,
    output sq_ready, xfer_buf_select, mwrite_enable, tbm_address,
           status_update_enable, cmdq_index, cmd_status, busy
  );
endinterface

// File: rtl/cmd_dispatch.sv
// Command dispatcher: decodes one CDB, issues one TBM block transfer per block, reports status.
// Optional per-block watchdog enabled by defining CMD_TIMEOUT_EN.
module cmd_dispatch #(
  parameter int BLK_SHIFT      = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clock_fpga,
  input  logic         reset_n,
  cmd_dispatch_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    STATUS = 3'd4
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h40;
  localparam logic [7:0] OP_READ  = 8'h30;
  localparam logic [1:0] ST_OK    = 2'b11;
  localparam logic [1:0] ST_UNSUP = 2'b01;

  state_t      state_r, state_n;
  logic [7:0]  opcode_r, tag_r;
  logic [31:0] lba_r;
  logic [15:0] count_r, blk_r, blk_n;
  logic [1:0]  status_s;
  logic        is_write_s;
  logic [31:0] addr_sum_s, tbm_next_s;

  logic        sq_ready_r, busy_r, xfer_buf_select_r, mwrite_enable_r;
  logic [31:0] tbm_address_r;
  logic        status_update_enable_r;
  logic [7:0]  cmdq_index_r;
  logic [1:0]  cmd_status_r;

  logic        unused_cdb_bits;
  assign unused_cdb_bits = ^{bus.cmd_out[255:112], bus.cmd_out[95:64], bus.cmd_out[31:16]};

`ifdef CMD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ST_ERR = 2'b10;
  logic [WD_W-1:0] wd_r;

  // Per-block watchdog: cleared on entry to WAIT, counts every cycle spent in WAIT.
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      wd_r <= '0;
    end else if (state_n == WAIT && state_r != WAIT) begin
      wd_r <= '0;
    end else if (state_r == WAIT) begin
      wd_r <= wd_r + WD_W'(1);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  assign is_write_s = (opcode_r == OP_WRITE);
  assign addr_sum_s = lba_r + {16'h0000, blk_n};
  assign tbm_next_s = addr_sum_s << BLK_SHIFT;

  // Next-state, next block index and completion status.
  always_comb begin
    state_n  = state_r;
    blk_n    = blk_r;
    status_s = 2'b00;
    case (state_r)
      IDLE: begin
        if (bus.sq_select) begin
          state_n = DECODE;
        end else begin
          state_n = IDLE;
        end
      end
      DECODE: begin
        if (opcode_r == OP_WRITE || opcode_r == OP_READ) begin
          if (count_r != 16'd0) begin
            blk_n   = 16'd0;
            state_n = ISSUE;
          end else begin
            status_s = ST_OK;
            state_n  = STATUS;
          end
        end else begin
          status_s = ST_UNSUP;
          state_n  = STATUS;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (bus.xfer_complete) begin
          blk_n = blk_r + 16'd1;
          if (blk_n == count_r) begin
            status_s = ST_OK;
            state_n  = STATUS;
          end else begin
            state_n = ISSUE;
          end
        end
`ifdef CMD_TIMEOUT_EN
        else if (wd_r == WD_LAST) begin
          status_s = ST_ERR;
          state_n  = STATUS;
        end
`endif
        else begin
          state_n = WAIT;
        end
      end
      STATUS: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, latched CDB fields and registered outputs (derived from the next state).
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_r                <= IDLE;
      opcode_r               <= 8'h00;
      tag_r                  <= 8'h00;
      lba_r                  <= 32'h0000_0000;
      count_r                <= 16'h0000;
      blk_r                  <= 16'h0000;
      sq_ready_r             <= 1'b1;
      busy_r                 <= 1'b0;
      xfer_buf_select_r      <= 1'b0;
      mwrite_enable_r        <= 1'b0;
      tbm_address_r          <= 32'h0000_0000;
      status_update_enable_r <= 1'b0;
      cmdq_index_r           <= 8'h00;
      cmd_status_r           <= 2'b00;
    end else begin
      state_r <= state_n;
      blk_r   <= blk_n;
      if (state_r == IDLE && bus.sq_select) begin
        opcode_r <= bus.cmd_out[7:0];
        tag_r    <= bus.cmd_out[15:8];
        lba_r    <= bus.cmd_out[63:32];
        count_r  <= bus.cmd_out[111:96];
      end
      sq_ready_r             <= (state_n == IDLE);
      busy_r                 <= (state_n != IDLE);
      xfer_buf_select_r      <= (state_n == ISSUE);
      status_update_enable_r <= (state_n == STATUS);
      if (state_n == ISSUE) begin
        mwrite_enable_r <= is_write_s;
        tbm_address_r   <= tbm_next_s;
      end
      if (state_n == STATUS) begin
        cmdq_index_r <= tag_r;
        cmd_status_r <= status_s;
      end
    end
  end

  assign bus.sq_ready             = sq_ready_r;
  assign bus.busy                 = busy_r;
  assign bus.xfer_buf_select      = xfer_buf_select_r;
  assign bus.mwrite_enable        = mwrite_enable_r;
  assign bus.tbm_address          = tbm_address_r;
  assign bus.status_update_enable = status_update_enable_r;
  assign bus.cmdq_index           = cmdq_index_r;
  assign bus.cmd_status           = cmd_status_r;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: directed cases plus random commands against a reference model.
module tb_cmd_dispatch;
`ifdef CMD_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif
  localparam int BS = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nfail = 0;

  cmd_dispatch_if bus();

  cmd_dispatch #(.BLK_SHIFT(BS), .TIMEOUT_CYCLES(TO)) dut (
    .clock_fpga(clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected TBM byte address of block i: (lba + i) * block_size, modulo 2^32.
  function automatic logic [31:0] exp_addr(input logic [31:0] lba, input int i);
    logic [63:0] a;
    a = (64'(lba) + 64'(i)) * (64'd1 << BS);
    return a[31:0];
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},  bus.sq_ready, 1);
    check({tag, "_busy"},   bus.busy, 0);
    check({tag, "_sel"},    bus.xfer_buf_select, 0);
    check({tag, "_mwr"},    bus.mwrite_enable, 0);
    check({tag, "_addr"},   bus.tbm_address, 0);
    check({tag, "_sue"},    bus.status_update_enable, 0);
    check({tag, "_idx"},    bus.cmdq_index, 0);
    check({tag, "_status"}, bus.cmd_status, 0);
  endtask

  function automatic logic [255:0] make_cdb(input logic [7:0] op, input logic [7:0] tag,
                                            input logic [31:0] lba, input logic [15:0] cnt);
    logic [255:0] c;
    for (int k = 0; k < 8; k++) c[k*32 +: 32] = $urandom;
    c[7:0]    = op;
    c[15:8]   = tag;
    c[63:32]  = lba;
    c[111:96] = cnt;
    return c;
  endfunction

  // Issue one command and check every transfer and the completion report.
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] tag, input logic [31:0] lba,
                         input logic [15:0] cnt, input int lat, input bit stray, input bit junk);
    int nx;
    bit supported;
    check("ready_before_cmd", bus.sq_ready, 1);
    bus.cmd_out   = make_cdb(op, tag, lba, cnt);
    bus.sq_select = 1'b1;
    tick();
    check("busy_after_accept", {bus.sq_ready, bus.busy}, 2'b01);
    if (junk) begin
      bus.cmd_out   = make_cdb(8'h99, ~tag, ~lba, cnt + 16'd3);
      bus.sq_select = 1'b1;
    end else begin
      bus.sq_select = 1'b0;
    end
    tick();
    bus.sq_select = 1'b0;
    supported = (op == 8'h40) || (op == 8'h30);
    nx = supported ? int'(cnt) : 0;
    for (int i = 0; i < nx; i++) begin
      check("xfer_sel", bus.xfer_buf_select, 1);
      check("mwrite", bus.mwrite_enable, (op == 8'h40));
      check("tbm_addr", bus.tbm_address, exp_addr(lba, i));
      check("no_status_mid_cmd", bus.status_update_enable, 0);
      for (int j = 1; j < lat; j++) begin
        bus.xfer_complete = (j == 1) && stray;
        tick();
        bus.xfer_complete = 1'b0;
        check("sel_one_cycle", bus.xfer_buf_select, 0);
      end
      bus.xfer_complete = 1'b1;
      tick();
      bus.xfer_complete = 1'b0;
    end
    check("status_en", bus.status_update_enable, 1);
    check("cmdq_index", bus.cmdq_index, tag);
    check("cmd_status", bus.cmd_status, supported ? 2'b11 : 2'b01);
    check("no_sel_at_status", bus.xfer_buf_select, 0);
    check("ready_low_at_status", bus.sq_ready, 0);
    tick();
    check("status_pulse_end", bus.status_update_enable, 0);
    check("ready_after_status", {bus.sq_ready, bus.busy}, 2'b10);
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] lba;
    logic [15:0] cnt;
    bus.sq_select     = 1'b0;
    bus.cmd_out       = '0;
    bus.xfer_complete = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    check_reset_vals("post_reset");

    run_cmd(8'h40, 8'h05, 32'h0000_0000, 16'd8, 3, 1'b0, 1'b0);
    run_cmd(8'h30, 8'h11, 32'h0000_0010, 16'd2, 3, 1'b0, 1'b0);
    run_cmd(8'h99, 8'h07, 32'h0000_0000, 16'd4, 3, 1'b0, 1'b0);
    run_cmd(8'h40, 8'h21, 32'h0000_1234, 16'd0, 3, 1'b0, 1'b0);
    run_cmd(8'h30, 8'h33, 32'h0000_0100, 16'd3, 2, 1'b1, 1'b1);
    run_cmd(8'h40, 8'h44, 32'hFFFF_FFFF, 16'd2, 2, 1'b1, 1'b0);

    // Reset asserted while waiting for a block completion.
    bus.cmd_out   = make_cdb(8'h40, 8'h2A, 32'h0000_0005, 16'd4);
    bus.sq_select = 1'b1;
    tick();
    bus.sq_select = 1'b0;
    tick();
    check("rst_case_sel", bus.xfer_buf_select, 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_wait_reset");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.xfer_complete = (k == 0);
      tick();
      bus.xfer_complete = 1'b0;
      check("no_status_after_reset", bus.status_update_enable, 0);
      check("no_sel_after_reset", bus.xfer_buf_select, 0);
    end

`ifdef CMD_TIMEOUT_EN
    bus.cmd_out   = make_cdb(8'h40, 8'h5C, 32'h0000_0000, 16'd3);
    bus.sq_select = 1'b1;
    tick();
    bus.sq_select = 1'b0;
    tick();
    check("to_sel", bus.xfer_buf_select, 1);
    for (int k = 1; k < 17; k++) begin
      tick();
      check("to_no_status_yet", bus.status_update_enable, 0);
    end
    tick();
    check("to_status_en", bus.status_update_enable, 1);
    check("to_status", bus.cmd_status, 2'b10);
    check("to_index", bus.cmdq_index, 8'h5C);
    bus.xfer_complete = 1'b1;
    tick();
    bus.xfer_complete = 1'b0;
    check("to_late_sel", bus.xfer_buf_select, 0);
    check("to_late_ready", bus.sq_ready, 1);
    tick();
    check("to_late_no_status", bus.status_update_enable, 0);
`endif

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0: op = 8'h40;
        1: op = 8'h30;
        2: op = 8'h40;
        default: op = 8'($urandom);
      endcase
      lba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
      cnt = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bus.xfer_complete = 1'($urandom);
        tick();
        bus.xfer_complete = 1'b0;
        check("idle_stray_no_sel", bus.xfer_buf_select, 0);
      end
      run_cmd(op, 8'($urandom), lba, cnt, $urandom_range(2, 5), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
